// File: rtl/pc_pkg.sv
// Shared types and defaults for the program counter and its return-address stack.
package pc_pkg;

    localparam int unsigned ADDR_W              = 16;
    localparam int unsigned DEPTH_W             = 4;
    localparam int unsigned DEFAULT_STACK_DEPTH = 4;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DEPTH_W-1:0] depth_t;

    localparam addr_t DEFAULT_RESET_VECTOR = 16'h0000;

    // The single action the PC performs in a given cycle, already prioritised.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_SET,
        ACT_RETURN,
        ACT_INTERRUPT,
        ACT_LOCKED
    } pc_action_e;

endpackage

// File: rtl/program_counter_if.sv
// Control and status bundle between the instruction sequencer (master) and the PC (slave).
interface program_counter_if
    import pc_pkg::*;
();

    addr_t  i_data_bus;
    addr_t  i_interrupt_address;
    logic   i_set_enable;
    logic   i_address_enable;
    logic   i_interrupt_enable;
    logic   i_lock;
    logic   i_increment;
    logic   i_return;

    addr_t  o_address_bus;
    addr_t  o_pc;
    logic   o_in_interrupt;
    logic   o_int_pending;
    depth_t o_stack_depth;
    logic   o_stack_overflow;
    logic   o_stack_underflow;

    modport master (
        output i_data_bus, i_interrupt_address, i_set_enable, i_address_enable,
               i_interrupt_enable, i_lock, i_increment, i_return,
        input  o_address_bus, o_pc, o_in_interrupt, o_int_pending, o_stack_depth,
               o_stack_overflow, o_stack_underflow
    );

    modport slave (
        input  i_data_bus, i_interrupt_address, i_set_enable, i_address_enable,
               i_interrupt_enable, i_lock, i_increment, i_return,
        output o_address_bus, o_pc, o_in_interrupt, o_int_pending, o_stack_depth,
               o_stack_overflow, o_stack_underflow
    );

endinterface

// File: rtl/return_stack.sv
// Return-address LIFO: plain push/pop storage, the caller decides when each may happen.
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   push,
    input  logic   pop,
    input  addr_t  push_data,
    output addr_t  top,
    output depth_t depth,
    output logic   full,
    output logic   empty
);

    addr_t  mem [DEPTH];
    depth_t count_q;

    assign depth = count_q;
    assign full  = (count_q == depth_t'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == depth_t'(i + 1)) top = mem[i];
        end
    end

    // NOTE: the storage array is reset here because cleared contents are observable
    // behaviour; sequential state is always written with <= so every flop samples
    // its pre-edge value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count_q <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count_q == depth_t'(i)) mem[i] <= push_data;
            end
            count_q <= count_q + depth_t'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - depth_t'(1);
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter with lock, latched interrupt entry and a return-address stack.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned STACK_DEPTH  = DEFAULT_STACK_DEPTH,
    parameter addr_t       RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input logic              clk,
    input logic              n_rst,
    program_counter_if.slave bus
);

    addr_t      pc_q;
    addr_t      pend_vec_q;
    addr_t      stack_top;
    addr_t      entry_vec;
    logic       pend_q;
    logic       ovf_q;
    logic       unf_q;
    logic       push;
    logic       pop;
    logic       stack_full;
    logic       stack_empty;
    depth_t     depth;
    pc_action_e action;

    // NOTE: the decode gets its default before any branch so no path infers a latch.
    always_comb begin
        action = ACT_HOLD;
        if (bus.i_lock)                              action = ACT_LOCKED;
        else if (pend_q || bus.i_interrupt_enable)   action = ACT_INTERRUPT;
        else if (bus.i_return)                       action = ACT_RETURN;
        else if (bus.i_set_enable)                   action = ACT_SET;
        else if (bus.i_increment)                    action = ACT_INC;
    end

    // A latched request is older than a live one, so it is always served first.
    assign entry_vec = pend_q ? pend_vec_q : bus.i_interrupt_address;
    assign push      = (action == ACT_INTERRUPT) && !stack_full;
    assign pop       = (action == ACT_RETURN) && !stack_empty;

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q),
        .top       (stack_top),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_vec_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            unique case (action)
                ACT_LOCKED: begin
                    if (bus.i_interrupt_enable) begin
                        pend_q     <= 1'b1;
                        pend_vec_q <= bus.i_interrupt_address;
                    end
                end
                ACT_INTERRUPT: begin
                    if (stack_full) ovf_q <= 1'b1;
                    else            pc_q  <= entry_vec;
                    // A live request arriving with a pending one becomes the next pending.
                    pend_q <= pend_q && bus.i_interrupt_enable;
                    if (bus.i_interrupt_enable) pend_vec_q <= bus.i_interrupt_address;
                end
                ACT_RETURN: begin
                    if (stack_empty) unf_q <= 1'b1;
                    else             pc_q  <= stack_top;
                end
                ACT_SET:  pc_q <= bus.i_data_bus;
                ACT_INC:  pc_q <= pc_q + addr_t'(1);
                default:  ;
            endcase
        end
    end

    assign bus.o_address_bus     = (n_rst && bus.i_address_enable) ? pc_q : '0;
    assign bus.o_pc              = pc_q;
    assign bus.o_in_interrupt    = (depth != '0);
    assign bus.o_int_pending     = pend_q;
    assign bus.o_stack_depth     = depth;
    assign bus.o_stack_overflow  = ovf_q;
    assign bus.o_stack_underflow = unf_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of program_counter against a queue-based reference model.
module tb_program_counter;
    import pc_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam addr_t       RV    = 16'h0000;

    logic clk;
    logic n_rst;
    int   tests_run;
    int   tests_failed;

    program_counter_if bus ();

    program_counter #(
        .STACK_DEPTH  (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state only, with the stack held as a queue.
    addr_t m_pc;
    addr_t m_stk[$];
    bit    m_pend;
    addr_t m_pvec;
    bit    m_ovf;
    bit    m_unf;

    task automatic model_reset();
        m_pc = RV;
        m_stk.delete();
        m_pend = 1'b0;
        m_pvec = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step();
        addr_t vec;
        if (bus.i_lock) begin
            if (bus.i_interrupt_enable) begin
                m_pend = 1'b1;
                m_pvec = bus.i_interrupt_address;
            end
        end else if (m_pend || bus.i_interrupt_enable) begin
            vec = m_pend ? m_pvec : bus.i_interrupt_address;
            if (m_pend && bus.i_interrupt_enable) m_pvec = bus.i_interrupt_address;
            else                                  m_pend = 1'b0;
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else begin
                m_stk.push_back(m_pc);
                m_pc = vec;
            end
        end else if (bus.i_return) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else                   m_pc  = m_stk.pop_back();
        end else if (bus.i_set_enable) begin
            m_pc = bus.i_data_bus;
        end else if (bus.i_increment) begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_pc"},    bus.o_pc, m_pc);
        check({tag, "_depth"}, 16'(bus.o_stack_depth), 16'(m_stk.size()));
        check({tag, "_inint"}, 16'(bus.o_in_interrupt), 16'(m_stk.size() != 0));
        check({tag, "_pend"},  16'(bus.o_int_pending), 16'(m_pend));
        check({tag, "_ovf"},   16'(bus.o_stack_overflow), 16'(m_ovf));
        check({tag, "_unf"},   16'(bus.o_stack_underflow), 16'(m_unf));
        check({tag, "_abus"},  bus.o_address_bus,
              (n_rst && bus.i_address_enable) ? m_pc : 16'h0000);
    endtask

    task automatic idle();
        bus.i_data_bus          = '0;
        bus.i_interrupt_address = '0;
        bus.i_set_enable        = 1'b0;
        bus.i_address_enable    = 1'b0;
        bus.i_interrupt_enable  = 1'b0;
        bus.i_lock              = 1'b0;
        bus.i_increment         = 1'b0;
        bus.i_return            = 1'b0;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
        idle();
    endtask

    task automatic do_reset(input string tag);
        idle();
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic irq(input addr_t vec, input logic lock);
        bus.i_interrupt_enable  = 1'b1;
        bus.i_interrupt_address = vec;
        bus.i_lock              = lock;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_rst        = 1'b0;
        idle();
        model_reset();

        // Reset state, with the address bus enabled to prove it stays zero.
        bus.i_address_enable = 1'b1;
        #2;
        compare_all("reset");
        check("reset_abus_const", bus.o_address_bus, 16'h0000);
        check("reset_pc_const", bus.o_pc, RV);
        do_reset("reset2");

        // Five increments, then address bus gating.
        for (int i = 0; i < 5; i++) begin
            bus.i_increment = 1'b1;
            tick("inc");
        end
        check("inc5_pc", bus.o_pc, 16'h0005);
        check("inc5_abus_off", bus.o_address_bus, 16'h0000);
        bus.i_address_enable = 1'b1;
        #1;
        check("inc5_abus_on", bus.o_address_bus, 16'h0005);

        // Interrupt entry and return.
        bus.i_set_enable = 1'b1;
        bus.i_data_bus   = 16'h0010;
        tick("set10");
        irq(16'hFDA9, 1'b0);
        tick("irq");
        check("irq_pc", bus.o_pc, 16'hFDA9);
        check("irq_depth", 16'(bus.o_stack_depth), 16'd1);
        bus.i_return = 1'b1;
        tick("ret");
        check("ret_pc", bus.o_pc, 16'h0010);
        check("ret_depth", 16'(bus.o_stack_depth), 16'd0);

        // Interrupt during lock, serviced on release; locked set/inc/return dropped.
        irq(16'hFB53, 1'b1);
        bus.i_increment = 1'b1;
        bus.i_return    = 1'b1;
        tick("lock_irq");
        check("lock_pc", bus.o_pc, 16'h0010);
        check("lock_pend", 16'(bus.o_int_pending), 16'd1);
        tick("unlock");
        check("unlock_pc", bus.o_pc, 16'hFB53);
        check("unlock_pend", 16'(bus.o_int_pending), 16'd0);
        bus.i_return = 1'b1;
        tick("unlock_ret");

        // Pending overwrite, pending+live coincidence, return+interrupt collision.
        irq(16'h1111, 1'b1);
        tick("ovw1");
        irq(16'h2222, 1'b1);
        tick("ovw2");
        irq(16'h3333, 1'b0);
        tick("coinc");
        check("coinc_pc", bus.o_pc, 16'h2222);
        check("coinc_pend", 16'(bus.o_int_pending), 16'd1);
        tick("coinc_drain");
        check("drain_pc", bus.o_pc, 16'h3333);
        irq(16'h4444, 1'b0);
        bus.i_return = 1'b1;
        tick("ret_irq");
        check("ret_irq_pc", bus.o_pc, 16'h4444);
        check("ret_irq_depth", 16'(bus.o_stack_depth), 16'd3);
        for (int i = 0; i < 3; i++) begin
            bus.i_return = 1'b1;
            tick("unwind");
        end
        check("unwind_pc", bus.o_pc, 16'h0010);

        // Increment wrap.
        bus.i_set_enable = 1'b1;
        bus.i_data_bus   = 16'hFFFF;
        tick("setff");
        bus.i_increment = 1'b1;
        tick("wrap");
        check("wrap_pc", bus.o_pc, 16'h0000);
        check("wrap_unf", 16'(bus.o_stack_underflow), 16'd0);

        // Overflow on the fifth nested interrupt.
        do_reset("reset3");
        for (int i = 1; i <= 5; i++) begin
            irq(16'hA000 + 16'(i), 1'b0);
            tick("nest");
        end
        check("ovf_depth", 16'(bus.o_stack_depth), 16'd4);
        check("ovf_flag", 16'(bus.o_stack_overflow), 16'd1);
        check("ovf_pc", bus.o_pc, 16'hA004);
        tick("ovf_sticky");

        // Unwind, then underflow; set beats increment.
        for (int i = 0; i < 4; i++) begin
            bus.i_return = 1'b1;
            tick("pop");
        end
        bus.i_return = 1'b1;
        tick("unf");
        check("unf_flag", 16'(bus.o_stack_underflow), 16'd1);
        check("unf_pc", bus.o_pc, 16'h0000);
        bus.i_set_enable = 1'b1;
        bus.i_data_bus   = 16'h1234;
        bus.i_increment  = 1'b1;
        tick("set_inc");
        check("set_inc_pc", bus.o_pc, 16'h1234);

        // Asynchronous reset landing while a push is being requested.
        irq(16'hBEEF, 1'b0);
        tick("pre_push");
        irq(16'hCAFE, 1'b0);
        bus.i_address_enable = 1'b1;
        #3;
        n_rst = 1'b0;
        #1;
        model_reset();
        compare_all("mid_push_rst");
        check("mid_push_pc", bus.o_pc, RV);
        check("mid_push_depth", 16'(bus.o_stack_depth), 16'd0);
        idle();
        @(negedge clk);
        n_rst = 1'b1;
        bus.i_return = 1'b1;
        tick("post_rst_ret");

        // Randomized traffic against the model.
        do_reset("reset4");
        for (int n = 0; n < 600; n++) begin
            bus.i_lock              = ($urandom_range(0, 9) < 2);
            bus.i_interrupt_enable  = ($urandom_range(0, 9) < 3);
            bus.i_interrupt_address = 16'($urandom);
            bus.i_return            = ($urandom_range(0, 9) < 3);
            bus.i_set_enable        = ($urandom_range(0, 9) < 2);
            bus.i_data_bus          = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            bus.i_increment         = ($urandom_range(0, 9) < 5);
            bus.i_address_enable    = 1'($urandom_range(0, 1));
            tick("rand");
            if (n == 300) do_reset("rand_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter STACK_DEPTH, default 4, is the number of return-address stack entries (range 2..8).
REQ-002 Parameter RESET_VECTOR, default 16'h0000, is the PC value loaded on reset.
REQ-003 clk  input  1  rising-edge system clock; the block has one clock.
REQ-004 n_rst  input  1  reset, asynchronous and active-low.
REQ-005 i_data_bus  input  16  jump target for i_set_enable.
REQ-006 i_interrupt_address  input  16  interrupt vector from the controller.
REQ-007 i_set_enable  input  1  load PC from i_data_bus.
REQ-008 i_address_enable  input  1  drive PC onto o_address_bus.
REQ-009 i_interrupt_enable  input  1  one-cycle interrupt entry request.
REQ-010 i_lock  input  1  freeze PC and stack.
REQ-011 i_increment  input  1  PC <= PC + 1.
REQ-012 i_return  input  1  return from interrupt: pop stack into PC.
REQ-013 o_address_bus  output  16  PC when i_address_enable = 1, else 16'h0000.
REQ-014 o_pc  output  16  current PC register.
REQ-015 o_in_interrupt  output  1  stack depth is non-zero.
REQ-016 o_int_pending  output  1  an interrupt is latched during lock.
REQ-017 o_stack_depth  output  4  occupied stack entries.
REQ-018 o_stack_overflow  output  1  sticky overflow flag.
REQ-019 o_stack_underflow  output  1  sticky underflow flag.

Function
REQ-020 All state updates shall occur on the rising edge of clk; o_address_bus shall be combinational from PC and i_address_enable.
REQ-021 Per-cycle action priority, unlocked: interrupt (live or pending) > return > set > increment > hold.
REQ-022 Interrupt entry shall push the current PC, load PC with the vector, and increment depth by 1, all in one cycle.
REQ-023 A live i_interrupt_enable shall take its vector from the same cycle; a pending entry shall use the vector captured at latch time.
REQ-024 If a live interrupt and a pending interrupt coincide, the pending entry is taken first and the live one is latched as the new pending entry.
REQ-025 Return shall load PC with the top-of-stack entry and decrement depth by 1.
REQ-026 Increment shall wrap 16'hFFFF to 16'h0000 with no flag.
REQ-027 With i_lock = 1, PC, stack, and depth shall hold, and set, increment, and return shall be dropped.
REQ-028 An interrupt during lock shall set pending and capture its vector; a second interrupt while pending shall overwrite the vector.
REQ-029 Pending shall be serviced on the first unlocked cycle and shall then clear.
REQ-030 Interrupt entry at depth = STACK_DEPTH shall leave PC and stack unchanged, drop the request, and set o_stack_overflow.
REQ-031 Return at depth 0 shall leave PC unchanged and set o_stack_underflow.
REQ-032 Overflow and underflow flags shall clear only on reset.
REQ-033 Return plus interrupt in the same cycle shall perform the interrupt only; the return is dropped.

Reset
REQ-034 While n_rst = 0: PC = RESET_VECTOR, depth = 0, pending = 0, both flags = 0, stack contents = 16'h0000, and o_address_bus = 16'h0000.
REQ-035 Reset asserted mid-operation shall abort any push, pop, or pending entry immediately, with no partial update.

Structure
REQ-036 The shared package pc_pkg shall hold ADDR_W = 16, the default RESET_VECTOR, and the default STACK_DEPTH.
REQ-037 The stack shall be a sub-module, return_stack, with push/pop/top/depth/full/empty ports and no priority logic.

Verification
REQ-038 Reset, then 5 cycles of i_increment -> o_pc = 16'h0005; o_address_bus = 16'h0005 only when i_address_enable = 1.
REQ-039 PC = 16'h0010, i_interrupt_enable with vector 16'hFDA9 -> next cycle o_pc = 16'hFDA9 and depth = 1; then i_return -> o_pc = 16'h0010 and depth = 0.
REQ-040 i_lock = 1 and interrupt with vector 16'hFB53 -> o_pc unchanged and o_int_pending = 1; lock released -> next cycle o_pc = 16'hFB53 and pending = 0.
REQ-041 Five nested interrupts (STACK_DEPTH = 4) -> depth = 4, fifth dropped, o_stack_overflow = 1, o_pc = fourth vector.
REQ-042 i_return at depth 0 -> o_stack_underflow = 1 and o_pc unchanged; i_set_enable with 16'h1234 plus i_increment in the same cycle -> o_pc = 16'h1234.
REQ-043 o_pc = 16'hFFFF, i_increment -> 16'h0000; n_rst pulsed mid-push -> o_pc = RESET_VECTOR and depth = 0.
